// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, LATENCY wait states, word-organised
// little-endian RAM with byte/half/word sizing and misalignment/range error detection.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_op,
  input  logic        req_ext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 0..15");
  end

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  op_q, op_d;
  logic        ext_q, ext_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // Access fields: live request inputs while IDLE (LATENCY=0 enters RESP on the
  // accepting edge), otherwise the captured copy.
  logic        a_we;
  logic [1:0]  a_op;
  logic        a_ext;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [29:0] a_idx;
  logic        a_err;
  logic [31:0] rd_word;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] ld_data;
  logic [3:0]  be;
  logic [31:0] wmask;
  logic [31:0] wsh;
  logic [31:0] wr_word;
  logic        enter_resp;
  logic        mem_we;

  always_comb begin
    a_we    = we_q;
    a_op    = op_q;
    a_ext   = ext_q;
    a_addr  = addr_q;
    a_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      a_we    = req_we;
      a_op    = req_op;
      a_ext   = req_ext;
      a_addr  = req_addr;
      a_wdata = req_wdata;
    end
  end

  assign a_idx = a_addr[31:2];

  always_comb begin
    a_err = (a_op == 2'b11)
          | ((a_op == 2'b00) & (a_addr[1:0] != 2'b00))
          | ((a_op == 2'b01) & a_addr[0])
          | ({2'b00, a_idx} >= 32'(DEPTH_WORDS));
  end

  assign rd_word = mem[a_idx[AW-1:0]];

  always_comb begin
    sel_b = rd_word[7:0];
    case (a_addr[1:0])
      2'd1:    sel_b = rd_word[15:8];
      2'd2:    sel_b = rd_word[23:16];
      2'd3:    sel_b = rd_word[31:24];
      default: sel_b = rd_word[7:0];
    endcase
    sel_h = a_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (a_op)
      2'b00:   ld_data = rd_word;
      2'b01:   ld_data = {{16{a_ext & sel_h[15]}}, sel_h};
      2'b10:   ld_data = {{24{a_ext & sel_b[7]}}, sel_b};
      default: ld_data = 32'd0;
    endcase
  end

  // Store merge: only the addressed lanes change.
  always_comb begin
    case (a_op)
      2'b00:   be = 4'b1111;
      2'b01:   be = 4'b0011 << a_addr[1:0];
      2'b10:   be = 4'b0001 << a_addr[1:0];
      default: be = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      wmask[8*i +: 8] = {8{be[i]}};
    end
    wsh     = a_wdata << {a_addr[1:0], 3'b000};
    wr_word = (rd_word & ~wmask) | (wsh & wmask);
  end

  // Handshake: a request transfers on an edge where req_valid && req_ready (IDLE only);
  // a response transfers on an edge where rsp_valid && rsp_ready, and rsp_* hold until then.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    op_d       = op_q;
    ext_d      = ext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          op_d    = req_op;
          ext_d   = req_ext;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = a_err;
      rdata_d = (a_err | a_we) ? 32'd0 : ld_data;
    end
    mem_we = enter_resp & a_we & ~a_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      op_q    <= 2'b00;
      ext_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      op_q    <= op_d;
      ext_q   <= ext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset and are undefined at power-up.
  always_ff @(posedge clk) begin
    if (mem_we) mem[a_idx[AW-1:0]] <= wr_word;
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

endmodule
